multiport_reg_file: RTL and testbench
=====================================

Name: multiport_reg_file

Overview:
- Parametrised successor of the single-write, two-read MIPS register file.
- Adds configurable width, depth and read-port count, two write ports with fixed priority, and optional write-to-read bypass.
- Adds a hardware clear sequencer that zeroes every entry after reset or on request, with a ready flag.
- Sits in the decode stage; serves the superscalar/dual-writeback datapath.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, >=2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clearReq  in  1  synchronous request to re-zero the whole file.
- readAddr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- readData  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
- wrEn0  in  1  write enable, port 0.
- wrAddr0  in  ADDR_W  write address, port 0.
- wrData0  in  DATA_W  write data, port 0.
- wrEn1  in  1  write enable, port 1 (higher priority).
- wrAddr1  in  ADDR_W  write address, port 1.
- wrData1  in  DATA_W  write data, port 1.
- ready  out  1  1 = clear finished, file usable.

Behaviour:
- State machine: CLEAR, RUN.
- Reset (rst_n=0, async):
  - state=CLEAR, clrPtr=0, ready=0.
  - Storage contents are not reset directly; the sweep zeroes them.
- CLEAR state:
  - Each cycle writes 0 to entry clrPtr, then clrPtr++.
  - In the cycle clrPtr==DEPTH-1: write 0, go to RUN, clrPtr=0.
  - ready rises on the following edge, exactly DEPTH cycles after the first clk edge with rst_n=1.
  - wrEn0/wrEn1 are ignored (dropped, not queued).
  - All readData outputs are 0.
  - clearReq is ignored.
- RUN state:
  - clearReq=1 sampled at an edge sets state=CLEAR, clrPtr=0, ready=0.
  - Writes presented in that same cycle are still performed.
- Writes (RUN only), committed at the rising edge.
  - wrEn0 and wrEn1 to the same address: port 1 value stored.
  - ZERO_REG=1: writes to address 0 are discarded.
- Reads:
  - Combinational from the array; zero-latency.
  - ZERO_REG=1 and address 0: data 0 regardless of bypass.
- Bypass (BYPASS=1, RUN):
  - A read address matching an enabled write address in the same cycle returns that write data.
  - If both ports match, wrData1 is returned.
- Bypass (BYPASS=0): reads return the pre-edge stored value.
- Ports are independent: any number of read ports may use the same address.
- rst_n asserted mid-sweep or mid-RUN: immediate return to CLEAR.
  - ready=0 and readData=0 combinationally via state.
  - The sweep restarts from 0 after deassertion.
- Out-of-range addresses cannot occur: DEPTH is a power of two.

Test Plan:
- Reset sweep: rst_n low 3 cycles then high. Require ready=0 for 32 cycles, ready=1 on the 32nd edge, and all 32 entries read 0. Apply wrEn0 during the sweep and require it to be dropped.
- Dual-write priority: in RUN, wrEn0=1 addr 5 data 0xAAAA0000 and wrEn1=1 addr 5 data 0x5555FFFF in the same cycle. Require the next-cycle read of 5 = 0x5555FFFF. Write ports 0 and 1 to addr 7 and 9 in one cycle and require both stored.
- Zero register: write 0xDEADBEEF to addr 0 via both ports. Require read of 0 = 0, including the same-cycle bypass read.
- Bypass: BYPASS=1, read addr 12 while wrEn0 writes 0x12345678 to 12. Require readData=0x12345678 in the same cycle. With BYPASS=0, require the old value in that cycle and the new value next cycle.
- clearReq in RUN: after filling entries 1..31 with their index, pulse clearReq together with a write of 0x77 to addr 3. Require ready low for 32 cycles, then every entry reads 0.
- Reset mid-sweep, using DEPTH=8, NUM_RD=4, DATA_W=16: assert rst_n at clrPtr=4. Require ready=0 immediately, then a full 8-cycle sweep after release. All 4 read ports reading the same addr must return identical data.

Source files
------------

// File: rtl/multiport_reg_file.sv
// multiport_reg_file: parametrised register file with NUM_RD combinational
// read ports, two prioritised write ports, optional write-to-read bypass and
// a clear sequencer that zeroes every entry after reset or on clearReq.
module multiport_reg_file #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clearReq,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] readAddr,
  output logic [NUM_RD*DATA_W-1:0]   readData,
  input  logic                       wrEn0,
  input  logic [$clog2(DEPTH)-1:0]   wrAddr0,
  input  logic [DATA_W-1:0]          wrData0,
  input  logic                       wrEn1,
  input  logic [$clog2(DEPTH)-1:0]   wrAddr1,
  input  logic [DATA_W-1:0]          wrData1,
  output logic                       ready
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clrPtr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wrOk0;
  logic wrOk1;

  // Write qualification: only in RUN, and never into a hard-wired zero entry.
  always_comb begin
    wrOk0 = 1'b0;
    wrOk1 = 1'b0;
    if (state == RUN) begin
      wrOk0 = wrEn0 && !((ZERO_REG != 0) && (wrAddr0 == '0));
      wrOk1 = wrEn1 && !((ZERO_REG != 0) && (wrAddr1 == '0));
    end
  end

  // Sequencer: sweep every entry once in CLEAR, then serve traffic in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrPtr <= '0;
    end else if (state == CLEAR) begin
      if (clrPtr == ADDR_W'(DEPTH - 1)) begin
        state  <= RUN;
        clrPtr <= '0;
      end else begin
        clrPtr <= clrPtr + 1'b1;
      end
    end else if (clearReq) begin
      state  <= CLEAR;
      clrPtr <= '0;
    end
  end

  // Storage update: sweep zeroes one entry per cycle; port 1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clrPtr] <= '0;
    end else begin
      if (wrOk0) mem[wrAddr0] <= wrData0;
      if (wrOk1) mem[wrAddr1] <= wrData1;
    end
  end

  // Read ports: zero while clearing, zero for entry 0, else bypass or stored value.
  always_comb begin
    readData = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (state == RUN) begin
        if ((ZERO_REG != 0) && (readAddr[i*ADDR_W +: ADDR_W] == '0)) begin
          readData[i*DATA_W +: DATA_W] = '0;
        end else if ((BYPASS != 0) && wrEn1 && (wrAddr1 == readAddr[i*ADDR_W +: ADDR_W])) begin
          readData[i*DATA_W +: DATA_W] = wrData1;
        end else if ((BYPASS != 0) && wrEn0 && (wrAddr0 == readAddr[i*ADDR_W +: ADDR_W])) begin
          readData[i*DATA_W +: DATA_W] = wrData0;
        end else begin
          readData[i*DATA_W +: DATA_W] = mem[readAddr[i*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  assign ready = (state == RUN);

endmodule

// File: tb/tb_multiport_reg_file.sv
// tb_multiport_reg_file: drives two instances (default 32x32 with bypass, and
// 8x16 with four read ports and no bypass) against a behavioural model.
module tb_multiport_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic checkEn = 1'b0;

  // Instance A: defaults
  logic        rstNA = 1'b0, clearReqA = 1'b0, readyA;
  logic [9:0]  readAddrA = '0;
  logic [63:0] readDataA;
  logic        wrEn0A = 1'b0, wrEn1A = 1'b0;
  logic [4:0]  wrAddr0A = '0, wrAddr1A = '0;
  logic [31:0] wrData0A = '0, wrData1A = '0;

  // Instance B: DEPTH=8, NUM_RD=4, DATA_W=16, BYPASS=0
  logic        rstNB = 1'b0, clearReqB = 1'b0, readyB;
  logic [11:0] readAddrB = '0;
  logic [63:0] readDataB;
  logic        wrEn0B = 1'b0, wrEn1B = 1'b0;
  logic [2:0]  wrAddr0B = '0, wrAddr1B = '0;
  logic [15:0] wrData0B = '0, wrData1B = '0;

  multiport_reg_file dutA (
    .clk(clk), .rst_n(rstNA), .clearReq(clearReqA),
    .readAddr(readAddrA), .readData(readDataA),
    .wrEn0(wrEn0A), .wrAddr0(wrAddr0A), .wrData0(wrData0A),
    .wrEn1(wrEn1A), .wrAddr1(wrAddr1A), .wrData1(wrData1A),
    .ready(readyA)
  );

  multiport_reg_file #(.DATA_W(16), .DEPTH(8), .NUM_RD(4), .ZERO_REG(1), .BYPASS(0)) dutB (
    .clk(clk), .rst_n(rstNB), .clearReq(clearReqB),
    .readAddr(readAddrB), .readData(readDataB),
    .wrEn0(wrEn0B), .wrAddr0(wrAddr0B), .wrData0(wrData0B),
    .wrEn1(wrEn1B), .wrAddr1(wrAddr1B), .wrData1(wrData1B),
    .ready(readyB)
  );

  // Reference model: contents plus the number of sweep cycles still to go.
  logic [31:0] memA [32];
  logic [15:0] memB [8];
  int leftA = 32;
  int leftB = 8;

  // Model update for A: countdown sweep, then writes with port 1 last.
  always @(posedge clk or negedge rstNA) begin
    if (!rstNA) begin
      leftA <= 32;
    end else if (leftA > 0) begin
      memA[32 - leftA] <= '0;
      leftA <= leftA - 1;
    end else begin
      if (wrEn0A && wrAddr0A != 0) memA[wrAddr0A] <= wrData0A;
      if (wrEn1A && wrAddr1A != 0) memA[wrAddr1A] <= wrData1A;
      if (clearReqA) leftA <= 32;
    end
  end

  // Model update for B.
  always @(posedge clk or negedge rstNB) begin
    if (!rstNB) begin
      leftB <= 8;
    end else if (leftB > 0) begin
      memB[8 - leftB] <= '0;
      leftB <= leftB - 1;
    end else begin
      if (wrEn0B && wrAddr0B != 0) memB[wrAddr0B] <= wrData0B;
      if (wrEn1B && wrAddr1B != 0) memB[wrAddr1B] <= wrData1B;
      if (clearReqB) leftB <= 8;
    end
  end

  function automatic logic [31:0] expA(logic [4:0] a);
    if (leftA != 0) return '0;
    if (a == 0) return '0;
    if (wrEn1A && wrAddr1A == a) return wrData1A;
    if (wrEn0A && wrAddr0A == a) return wrData0A;
    return memA[a];
  endfunction

  function automatic logic [15:0] expB(logic [2:0] a);
    if (leftB != 0) return '0;
    if (a == 0) return '0;
    return memB[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++)
        checkOutput($sformatf("A.rd%0d", i), readDataA[i*32 +: 32], expA(readAddrA[i*5 +: 5]));
      checkOutput("A.ready", {31'd0, readyA}, {31'd0, leftA == 0});
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("B.rd%0d", i), {16'd0, readDataB[i*16 +: 16]},
                    {16'd0, expB(readAddrB[i*3 +: 3])});
      checkOutput("B.ready", {31'd0, readyB}, {31'd0, leftB == 0});
    end
  end

  task automatic applyStimulus(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic clr, input logic [4:0] ra0, input logic [4:0] ra1);
    wrEn0A = we0; wrAddr0A = wa0; wrData0A = wd0;
    wrEn1A = we1; wrAddr1A = wa1; wrData1A = wd1;
    clearReqA = clr; readAddrA = {ra1, ra0};
  endtask

  task automatic applyStimulusB(input logic we0, input logic [2:0] wa0, input logic [15:0] wd0,
                                input logic we1, input logic [2:0] wa1, input logic [15:0] wd1,
                                input logic clr, input logic [11:0] ra);
    wrEn0B = we0; wrAddr0B = wa0; wrData0B = wd0;
    wrEn1B = we1; wrAddr1B = wa1; wrData1B = wd1;
    clearReqB = clr; readAddrB = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic countSweepA(input string name);
    int cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (readyA) begin
        cyc = c;
        break;
      end
    end
    checkOutput(name, cyc, 32);
  endtask

  task automatic checkAllZeroA(input string name);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      #1;
      checkOutput(name, readDataA[31:0], 32'h0);
      tick();
    end
  endtask

  initial begin
    int cycB;
    // Reset sweep on both instances, with a write that must be dropped.
    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b1;
    rstNA = 1'b1;
    rstNB = 1'b1;
    applyStimulus(1, 5, 32'h11, 0, 0, 0, 0, 5, 5);
    countSweepA("A.resetSweepLen");
    checkAllZeroA("A.resetClearedEntry");

    // Dual-write priority, including same-cycle bypass of the winner.
    applyStimulus(1, 5, 32'hAAAA0000, 1, 5, 32'h5555FFFF, 0, 1, 5);
    #1; checkOutput("A.prioBypass", readDataA[63:32], 32'h5555FFFF);
    tick();
    applyStimulus(1, 7, 32'h7, 1, 9, 32'h9, 0, 5, 5);
    #1; checkOutput("A.prioStored", readDataA[31:0], 32'h5555FFFF);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 9);
    #1; checkOutput("A.dualWrite7", readDataA[31:0], 32'h7);
    checkOutput("A.dualWrite9", readDataA[63:32], 32'h9);
    tick();

    // Zero register.
    applyStimulus(1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 0, 0);
    #1; checkOutput("A.zeroBypass", readDataA[31:0], 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; checkOutput("A.zeroStored", readDataA[63:32], 32'h0);
    tick();

    // Bypass on A.
    applyStimulus(1, 12, 32'h12345678, 0, 0, 0, 0, 12, 3);
    #1; checkOutput("A.bypass", readDataA[31:0], 32'h12345678);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // No bypass on B: old value this cycle, new value next cycle.
    applyStimulusB(1, 4, 16'hBEEF, 0, 0, 0, 0, {4{3'd4}});
    tick();
    applyStimulusB(1, 4, 16'h1234, 0, 0, 0, 0, {4{3'd4}});
    #1; checkOutput("B.noBypassOld", {16'd0, readDataB[15:0]}, 32'h0000BEEF);
    tick();
    applyStimulusB(0, 0, 0, 0, 0, 0, 0, {4{3'd4}});
    #1; checkOutput("B.noBypassNew", {16'd0, readDataB[47:32]}, 32'h00001234);
    tick();

    // clearReq in RUN together with a write that is still performed.
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1, 5'(a), 32'(a), 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 3, 32'h77, 0, 0, 0, 1, 3, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("A.readyDropOnClear", {31'd0, readyA}, 32'h0);
    countSweepA("A.clearSweepLen");
    checkAllZeroA("A.clearReqEntry");

    // Reset mid-sweep on B at clrPtr=4.
    applyStimulusB(0, 0, 0, 0, 0, 0, 0, {4{3'd2}});
    rstNB = 1'b0;
    tick(); tick();
    rstNB = 1'b1;
    repeat (4) tick();
    #1; rstNB = 1'b0;
    #1; checkOutput("B.readyAsyncDrop", {31'd0, readyB}, 32'h0);
    checkOutput("B.readAsyncZero", readDataB[31:0], 32'h0);
    tick(); tick();
    rstNB = 1'b1;
    cycB = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (readyB) begin
        cycB = c;
        break;
      end
    end
    checkOutput("B.sweepLen", cycB, 8);

    // All four B ports on the same address.
    applyStimulusB(1, 6, 16'hCAFE, 0, 0, 0, 0, {4{3'd2}});
    tick();
    applyStimulusB(0, 0, 0, 0, 0, 0, 0, {4{3'd6}});
    #1;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("B.samePort%0d", i), {16'd0, readDataB[i*16 +: 16]}, 32'h0000CAFE);
    tick();

    // Randomised traffic on both instances, checked every cycle by the model.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] rb;
      applyStimulus($urandom_range(0, 1), 5'($urandom), $urandom,
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 63) == 0), 5'($urandom), 5'($urandom_range(0, 7)));
      rb = 3'($urandom);
      applyStimulusB($urandom_range(0, 1), 3'($urandom), 16'($urandom),
                     $urandom_range(0, 1), 3'($urandom), 16'($urandom),
                     ($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 3) == 0) ? {4{rb}} : 12'($urandom));
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulusB(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
